// File: rtl/fetch_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package  : fetch_stage_pkg
// Brief    : Shared constants and types for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] c_ST_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] c_ST_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] c_ST_DROP = 2'd3;

    localparam logic [31:0] c_NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] c_DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int unsigned c_ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_next;
    } fetch_entry_t;

    // Sequential PC step; 32-bit result wraps naturally.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Circular prefetch buffer with push/pop/flush and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = c_ENTRY_W,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned        PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   c_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_wr_ptr_next, w_rd_ptr_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic             w_full, w_do_push, w_do_pop;

    assign w_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~i_flush & ~w_full;
    assign w_do_pop  = i_pop & ~i_flush & ~o_empty;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (i_flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_do_push) begin
                w_wr_ptr_next = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                w_rd_ptr_next = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch with one-outstanding memory port, prefetch
//            queue and branch redirect that discards in-flight responses.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGrant,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    input  logic        pcSrc,
    input  logic [31:0] branchTarget,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] pcNext,
    output logic        valid
);

    localparam int unsigned      CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_M1 = CNT_W'(DEPTH - 1);

    logic [STATE_W-1:0] r_state, w_state_next;
    logic [31:0]        r_fpc, w_fpc_next;
    logic [31:0]        r_issued_pc, w_issued_pc_next;
    logic               w_push, w_pop, w_flush, w_empty;
    logic               w_room, w_room_after_push;
    logic [CNT_W-1:0]   w_count, w_count_no_push;
    fetch_entry_t       w_head, w_push_entry;

    // A redirect wins over a same-cycle consume: the head is stale anyway.
    assign w_flush = pcSrc;
    assign w_pop   = ~w_empty & ~stall & ~pcSrc;

    // Occupancy as it will be after this edge, before counting any push.
    assign w_count_no_push   = w_count - CNT_W'(w_pop);
    assign w_room            = (w_count_no_push < c_DEPTH);
    assign w_room_after_push = (w_count_no_push < c_DEPTH_M1);

    assign w_push_entry.instr   = imemRdata;
    assign w_push_entry.pc_next = pc_plus4(r_issued_pc);

    always_comb begin
        w_state_next     = r_state;
        w_fpc_next       = r_fpc;
        w_issued_pc_next = r_issued_pc;
        w_push           = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (pcSrc) begin
                    w_fpc_next   = branchTarget;
                    w_state_next = c_ST_REQ;
                end else if (w_room) begin
                    w_state_next = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (imemGrant) begin
                    w_issued_pc_next = r_fpc;
                    if (pcSrc) begin
                        w_fpc_next   = branchTarget;
                        w_state_next = c_ST_DROP;
                    end else begin
                        w_fpc_next   = pc_plus4(r_fpc);
                        w_state_next = c_ST_WAIT;
                    end
                end else if (pcSrc) begin
                    w_fpc_next = branchTarget;
                end
            end
            c_ST_WAIT: begin
                if (imemRvalid) begin
                    if (pcSrc) begin
                        w_fpc_next   = branchTarget;
                        w_state_next = c_ST_REQ;
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = w_room_after_push ? c_ST_REQ : c_ST_IDLE;
                    end
                end else if (pcSrc) begin
                    w_fpc_next   = branchTarget;
                    w_state_next = c_ST_DROP;
                end
            end
            c_ST_DROP: begin
                // A response arriving alongside a new redirect is still the
                // stale one, so leave DROP; otherwise keep waiting for it.
                if (pcSrc) begin
                    w_fpc_next = branchTarget;
                end
                if (imemRvalid) begin
                    w_state_next = c_ST_REQ;
                end
            end
            default: begin
                w_state_next = c_ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_REQ;
            r_fpc       <= RESET_PC;
            r_issued_pc <= RESET_PC;
        end else begin
            r_state     <= w_state_next;
            r_fpc       <= w_fpc_next;
            r_issued_pc <= w_issued_pc_next;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_queue (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // State resets to REQ, so the request is gated while reset is held.
    assign imemReq     = (r_state == c_ST_REQ) && reset;
    assign imemAddr    = r_fpc;
    assign valid       = ~w_empty && reset;
    assign instruction = valid ? w_head.instr : c_NOP_WORD;
    assign pcNext      = valid ? w_head.pc_next : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage with a latency-controlled
//            memory model and a second instance for reset-PC wraparound.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imemReq, imemGrant, imemRvalid, pcSrc, stall, valid;
    logic [31:0] imemAddr, imemRdata, branchTarget, instruction, pcNext;

    logic        w2_req, w2_grant, w2_rvalid, w2_valid;
    logic [31:0] w2_addr, w2_rdata, w2_instruction, w2_pcNext;

    always #5 clock = ~clock;

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clock(clock), .reset(reset), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemGrant(imemGrant), .imemRvalid(imemRvalid), .imemRdata(imemRdata),
        .pcSrc(pcSrc), .branchTarget(branchTarget), .stall(stall),
        .instruction(instruction), .pcNext(pcNext), .valid(valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
        .clock(clock), .reset(reset), .imemReq(w2_req), .imemAddr(w2_addr),
        .imemGrant(w2_grant), .imemRvalid(w2_rvalid), .imemRdata(w2_rdata),
        .pcSrc(1'b0), .branchTarget(32'h0), .stall(1'b0),
        .instruction(w2_instruction), .pcNext(w2_pcNext), .valid(w2_valid)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          grant_cnt = 0;
    int          grant_limit = 0;
    int          latency = 0;
    logic [31:0] next_pc;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model plus scoreboard monitor for the main instance.
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          lat_cnt = 0;
    initial begin
        imemGrant = 1'b0; imemRvalid = 1'b0; imemRdata = 32'h0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pend = 1'b0; imemGrant = 1'b0; imemRvalid = 1'b0;
            end else begin
                if (valid && !stall && !pcSrc) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_output: got %h/%h expected none", instruction, pcNext);
                    end else begin
                        check64("head", {instruction, pcNext}, exp_q.pop_front());
                    end
                end
                imemRvalid = 1'b0;
                if (pend) begin
                    if (lat_cnt == 0) begin
                        imemRvalid = 1'b1; imemRdata = mem_word(pend_addr); pend = 1'b0;
                    end else begin
                        lat_cnt--;
                    end
                end
                imemGrant = (grant_cnt < grant_limit);
                if (imemReq && imemGrant) begin
                    if (exp_addr_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_grant: got %h expected none", imemAddr);
                    end else begin
                        check64("grant_addr", {32'h0, imemAddr}, {32'h0, exp_addr_q.pop_front()});
                    end
                    grant_cnt++; pend = 1'b1; pend_addr = imemAddr; lat_cnt = latency;
                end
            end
        end
    end

    // Zero-latency memory for the wraparound instance; logs its first two events.
    logic        w2_pend = 1'b0;
    logic [31:0] w2_pend_addr = 32'h0;
    logic [31:0] w2_addr_log [2];
    logic [31:0] w2_instr_log [2];
    logic [31:0] w2_pcn_log [2];
    int          w2_ngrant = 0;
    int          w2_nout = 0;
    initial begin
        w2_grant = 1'b0; w2_rvalid = 1'b0; w2_rdata = 32'h0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                w2_pend = 1'b0; w2_grant = 1'b0; w2_rvalid = 1'b0;
            end else begin
                if (w2_valid && w2_nout < 2) begin
                    w2_instr_log[w2_nout] = w2_instruction;
                    w2_pcn_log[w2_nout]   = w2_pcNext;
                    w2_nout++;
                end
                w2_rvalid = w2_pend; w2_rdata = mem_word(w2_pend_addr); w2_pend = 1'b0;
                w2_grant = 1'b1;
                if (w2_req) begin
                    if (w2_ngrant < 2) w2_addr_log[w2_ngrant] = w2_addr;
                    w2_ngrant++; w2_pend = 1'b1; w2_pend_addr = w2_addr;
                end
            end
        end
    end

    task automatic fetch_run(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(next_pc);
            exp_q.push_back({mem_word(next_pc), next_pc + 32'd4});
            next_pc = next_pc + 32'd4;
        end
        grant_limit += n;
    endtask

    task automatic stale_grant();
        exp_addr_q.push_back(next_pc);
        grant_limit += 1;
    endtask

    // Returns on the posedge right after the k-th grant was accepted.
    task automatic wait_grant(input int k);
        int t;
        for (t = 0; t < 100; t++) begin
            @(posedge clock);
            if (grant_cnt >= k) break;
        end
        if (t == 100) begin
            n_cmp++; n_bad++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", grant_cnt, k);
        end
    endtask

    task automatic drain(input string name);
        int t;
        for (t = 0; t < 300; t++) begin
            @(posedge clock);
            if (exp_q.size() == 0 && exp_addr_q.size() == 0) break;
        end
        if (t == 300) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size() + exp_addr_q.size());
            exp_q.delete(); exp_addr_q.delete();
        end
        repeat (2) @(posedge clock);
        #1 check64({name, "_empty_out"}, {31'h0, valid, instruction, pcNext}, 64'h0);
    endtask

    initial begin
        int base;
        logic [31:0] head_pc;
        stall = 1'b0; pcSrc = 1'b0; branchTarget = 32'h0;

        // Reset state and release
        #3;
        check64("rst_req",   {63'h0, imemReq}, 64'h0);
        check64("rst_valid", {63'h0, valid}, 64'h0);
        check64("rst_instr", {32'h0, instruction}, 64'h0);
        check64("rst_pcnext", {32'h0, pcNext}, 64'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check64("first_req", {31'h0, imemReq, imemAddr}, {31'h0, 1'b1, 32'h0});
        next_pc = 32'h0;

        // Sequential stream and best-case latency
        base = grant_cnt;
        fetch_run(4);
        wait_grant(base + 1);
        #1 check64("lat_n1_valid", {63'h0, valid}, 64'h0);
        @(posedge clock);
        #1 check64("lat_n2_valid", {63'h0, valid}, 64'h1);
        drain("stream");

        // Back-pressure fills the queue, then releases without loss
        @(posedge clock); #1 stall = 1'b1;
        base = grant_cnt; head_pc = next_pc;
        fetch_run(5);
        repeat (8) @(posedge clock);
        #1;
        check64("stall_grants", 64'(grant_cnt - base), 64'd2);
        check64("stall_req_off", {63'h0, imemReq}, 64'h0);
        check64("stall_head", {31'h0, valid, instruction}, {31'h0, 1'b1, mem_word(head_pc)});
        stall = 1'b0;
        drain("stall");

        // Redirect coinciding with the response: no DROP
        latency = 0; base = grant_cnt;
        stale_grant();
        wait_grant(base + 1);
        #1 pcSrc = 1'b1; branchTarget = 32'h40;
        @(posedge clock); #1 pcSrc = 1'b0;
        check64("same_cycle_req", {31'h0, imemReq, imemAddr}, {31'h0, 1'b1, 32'h40});
        next_pc = 32'h40;
        fetch_run(2);
        drain("same_cycle");

        // Redirect while waiting: stale response dropped
        latency = 3; base = grant_cnt;
        stale_grant();
        wait_grant(base + 1);
        #1 pcSrc = 1'b1; branchTarget = 32'h40; latency = 0;
        @(posedge clock); #1 pcSrc = 1'b0;
        check64("drop_req_off", {63'h0, imemReq}, 64'h0);
        next_pc = 32'h40;
        fetch_run(1);
        drain("wait_redirect");

        // Second redirect while already dropping takes the newer target
        latency = 3; base = grant_cnt;
        stale_grant();
        wait_grant(base + 1);
        #1 pcSrc = 1'b1; branchTarget = 32'h100; latency = 0;
        @(posedge clock); #1 branchTarget = 32'h200;
        @(posedge clock); #1 pcSrc = 1'b0;
        next_pc = 32'h200;
        fetch_run(1);
        drain("drop_redirect");

        // Asynchronous reset in the middle of an outstanding request
        @(posedge clock); #1 stall = 1'b1;
        base = grant_cnt;
        fetch_run(1);
        wait_grant(base + 1);
        @(posedge clock);
        #1 check64("pre_reset_valid", {63'h0, valid}, 64'h1);
        latency = 5; base = grant_cnt;
        stale_grant();
        wait_grant(base + 1);
        #3 reset = 1'b0;
        #1;
        check64("async_rst_req", {63'h0, imemReq}, 64'h0);
        check64("async_rst_out", {31'h0, valid, instruction, pcNext}, 64'h0);
        exp_q.delete(); exp_addr_q.delete();
        stall = 1'b0; latency = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        next_pc = 32'h0;
        #1 check64("restart_req", {31'h0, imemReq, imemAddr}, {31'h0, 1'b1, 32'h0});
        fetch_run(2);
        drain("restart");

        // Reset PC at the top of the address space
        check64("wrap_counts", {32'h0, (w2_ngrant >= 2), 15'h0, (w2_nout >= 2)}, {32'h0, 1'b1, 15'h0, 1'b1});
        check64("wrap_addr0", {32'h0, w2_addr_log[0]}, {32'h0, 32'hFFFF_FFFC});
        check64("wrap_addr1", {32'h0, w2_addr_log[1]}, 64'h0);
        check64("wrap_out0", {w2_instr_log[0], w2_pcn_log[0]}, {mem_word(32'hFFFF_FFFC), 32'h0});
        check64("wrap_out1", {w2_instr_log[1], w2_pcn_log[1]}, {mem_word(32'h0), 32'h4});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, prefetch queue entries (legal 2..8).
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imemReq  output  1  instruction-memory request valid.
REQ-006 SHALL have port imemAddr  output  32  word-aligned fetch address, valid while imemReq=1.
REQ-007 SHALL have port imemGrant  input  1  request accepted this cycle when imemReq=1.
REQ-008 SHALL have port imemRvalid  input  1  read data valid; in order, at most one outstanding.
REQ-009 SHALL have port imemRdata  input  32  instruction word.
REQ-010 SHALL have port pcSrc  input  1  branch taken, redirect fetch (from EXE/MEM AND of zero and branch).
REQ-011 SHALL have port branchTarget  input  32  redirect address, sampled when pcSrc=1.
REQ-012 SHALL have port stall  input  1  IF/ID not consuming this cycle.
REQ-013 SHALL have port instruction  output  32  head instruction to IF/ID register.
REQ-014 SHALL have port pcNext  output  32  head instruction address + 4.
REQ-015 SHALL have port valid  output  1  instruction/pcNext meaningful.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, DROP.
REQ-017 SHALL hold fetch PC register fpc; imemAddr = fpc; fpc += 4 on each grant.
REQ-018 SHALL assert imemReq only in REQ; REQ entered when count + outstanding < DEPTH, else IDLE.
REQ-019 REQ -> WAIT on imemGrant; REQ holds with stable imemAddr without grant.
REQ-020 WAIT on imemRvalid SHALL push {imemRdata, issued address + 4} to queue, then REQ if room else IDLE.
REQ-021 valid SHALL equal queue non-empty; instruction/pcNext from head; when empty instruction=32'h0 (nop) and pcNext=0.
REQ-022 Pop SHALL occur when valid=1 and stall=0; simultaneous push and pop keeps count unchanged.
REQ-023 Push into full queue SHALL be impossible by REQ-018; count never exceeds DEPTH.
REQ-024 pcSrc=1 SHALL, next edge, flush queue (valid=0), set fpc=branchTarget, ignore same-cycle pop.
REQ-025 pcSrc in WAIT without imemRvalid, or in REQ with imemGrant SHALL go to DROP; otherwise to REQ.
REQ-026 pcSrc in WAIT with imemRvalid same cycle SHALL discard that data and go to REQ.
REQ-027 DROP SHALL discard next imemRvalid data (no push), then go to REQ.
REQ-028 pcSrc while in DROP SHALL update fpc to the newer branchTarget and remain in DROP.
REQ-029 fpc and pcNext arithmetic SHALL wrap modulo 2^32 (32'hFFFFFFFC + 4 = 0).
REQ-030 Best-case latency: grant cycle N, rvalid N+1, valid=1 at N+2.

Reset
REQ-031 reset low SHALL immediately force state=REQ, fpc=RESET_PC, queue empty, outstanding=0.
REQ-032 During reset outputs SHALL be imemReq=0, valid=0, instruction=0, pcNext=0; imemReq=1 first cycle after release.
REQ-033 reset mid-transaction SHALL abandon the outstanding request; memory side tolerates the lost response.

Structure
REQ-034 Shared package SHALL hold FSM state encoding, NOP word 32'h0, default RESET_PC.
REQ-035 Queue SHALL be sub-module fetch_queue (DEPTH entries, 64-bit payload, push/pop/flush/count).

Verification
REQ-036 Reset release, zero-latency memory, stall=0 -> imemAddr 0,4,8,...; instruction stream in order, pcNext 4,8,12.
REQ-037 stall held 5 cycles with DEPTH=2 -> at most 2 grants then imemReq=0; release -> same head, no loss or duplicate.
REQ-038 pcSrc=1, target 32'h40, while WAIT outstanding -> stale response dropped, next valid instruction is word at 32'h40, pcNext 32'h44.
REQ-039 pcSrc same cycle as imemRvalid -> data discarded, no DROP, next imemAddr 32'h40.
REQ-040 RESET_PC 32'hFFFFFFFC -> second fetch address 0, first pcNext 0.
REQ-041 reset asserted mid-WAIT -> outputs zero asynchronously; after release fetch restarts at RESET_PC.
